// File: rtl/tb_transmitter.sv
// Word source: sends an incrementing 4-bit value over a four-phase req/ack
// handshake (HANDSHAKE=1) or as single-cycle en strobes (HANDSHAKE=0).
module tb_transmitter #(
  parameter int unsigned HANDSHAKE = 1,
  parameter int unsigned GAP       = 3,
  parameter int unsigned COUNT     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       ack,
  output logic [3:0] data,
  output logic       req,
  output logic       en,
  output logic [7:0] sent_count,
  output logic       done
);

  localparam bit         HS       = (HANDSHAKE != 0);
  localparam logic [7:0] GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_REQ,
    S_RELEASE,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        ack_meta_q, ack_s_q;
  logic [3:0]  data_q, data_d;
  logic [7:0]  sent_q, sent_d;
  logic [7:0]  gap_q, gap_d;
  logic [31:0] burst_q, burst_d;
  logic        req_q, req_d;
  logic        en_q, en_d;
  logic        done_q, done_d;
  logic        word_done;

  // ack is asynchronous; only ack_s_q is used by the control logic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= ack;
      ack_s_q    <= ack_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      data_q  <= 4'd1;
      sent_q  <= '0;
      gap_q   <= '0;
      burst_q <= '0;
      req_q   <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sent_q  <= sent_d;
      gap_q   <= gap_d;
      burst_q <= burst_d;
      req_q   <= req_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    sent_d    = sent_q;
    gap_d     = gap_q;
    burst_d   = burst_q;
    word_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          burst_d = '0;
        end
      end
      S_SETUP:   state_d = HS ? S_REQ : S_PULSE;
      S_REQ:     if (ack_s_q) state_d = S_RELEASE;
      S_RELEASE: if (!ack_s_q) word_done = 1'b1;
      S_PULSE:   word_done = 1'b1;
      S_GAP: begin
        if (gap_q == 8'd0) state_d = S_SETUP;
        else               gap_d   = gap_q - 8'd1;
      end
      S_DONE:    if (!start) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (word_done) begin
      data_d  = data_q + 4'd1;
      sent_d  = sent_q + 8'd1;
      burst_d = burst_q + 32'd1;
      if ((COUNT != 0) && (burst_q + 32'd1 == COUNT)) begin
        state_d = S_DONE;
      end else if (GAP > 0) begin
        state_d = S_GAP;
        gap_d   = GAP_LAST;
      end else begin
        state_d = S_SETUP;
      end
    end
  end

  // Outputs are registered copies decoded from the next state.
  assign req_d  = (state_d == S_REQ);
  assign en_d   = (state_d == S_PULSE);
  assign done_d = (state_d == S_DONE);

  assign data       = data_q;
  assign req        = req_q;
  assign en         = en_q;
  assign sent_count = sent_q;
  assign done       = done_q;

endmodule

// File: tb/tb_tb_transmitter.sv
// Scoreboard bench for tb_transmitter: four instances (handshake, strobe with
// gap, strobe without gap, bounded burst) checked against a word-index model.
module tb_tb_transmitter;

  typedef struct packed {
    logic [3:0] d;
    logic [7:0] c;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Word i (0-based since reset) carries (i+1) mod 16 and finds i mod 256 words sent.
  function automatic exp_t word_at(input int unsigned i);
    exp_t e;
    e.d = 4'((i + 1) % 16);
    e.c = 8'(i % 256);
    return e;
  endfunction

  exp_t q_hs[$], q_st[$], q_g0[$], q_bu[$];

  logic rst_hs = 1'b0, rst_st = 1'b0, rst_g0 = 1'b0, rst_bu = 1'b0;
  logic start_hs = 1'b0, start_st = 1'b0, start_g0 = 1'b0, start_bu = 1'b0;
  logic ack_hs = 1'b0, ack_x = 1'b0, rx_block = 1'b1;
  logic [3:0] data_hs, data_st, data_g0, data_bu;
  logic req_hs, req_st, req_g0, req_bu;
  logic en_hs, en_st, en_g0, en_bu;
  logic [7:0] cnt_hs, cnt_st, cnt_g0, cnt_bu;
  logic done_hs, done_st, done_g0, done_bu;

  tb_transmitter #(.HANDSHAKE(1), .GAP(3), .COUNT(0)) u_hs (
    .clk(clk), .rst(rst_hs), .start(start_hs), .ack(ack_hs), .data(data_hs),
    .req(req_hs), .en(en_hs), .sent_count(cnt_hs), .done(done_hs));
  tb_transmitter #(.HANDSHAKE(0), .GAP(3), .COUNT(0)) u_st (
    .clk(clk), .rst(rst_st), .start(start_st), .ack(ack_x), .data(data_st),
    .req(req_st), .en(en_st), .sent_count(cnt_st), .done(done_st));
  tb_transmitter #(.HANDSHAKE(0), .GAP(0), .COUNT(0)) u_g0 (
    .clk(clk), .rst(rst_g0), .start(start_g0), .ack(ack_x), .data(data_g0),
    .req(req_g0), .en(en_g0), .sent_count(cnt_g0), .done(done_g0));
  tb_transmitter #(.HANDSHAKE(0), .GAP(1), .COUNT(4)) u_bu (
    .clk(clk), .rst(rst_bu), .start(start_bu), .ack(ack_x), .data(data_bu),
    .req(req_bu), .en(en_bu), .sent_count(cnt_bu), .done(done_bu));

  // Receiver: req through two flops, plus a random 0..2 cycle lag per change.
  logic req_seen = 1'b0, f1 = 1'b0, f2 = 1'b0, tgt;
  int   lag = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      f2  = f1;
      f1  = req_seen;
      tgt = f2 & ~rx_block;
      if (tgt != ack_hs) begin
        if (lag == 0) begin
          ack_hs = tgt;
          lag    = $urandom_range(2, 0);
        end else lag--;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    ack_x = 1'($urandom_range(1, 0));
  end

  // Monitors
  logic hs_req_p = 1'b0, hs_ack_p = 1'b0;
  logic [3:0] hs_word = 4'd0;
  int   hs_ack_cyc = -1, st_last = -1, g0_last = -1, bu_last = -1;
  exp_t e_hs, e_st, e_g0, e_bu;

  always @(negedge clk) begin
    req_seen = req_hs;
    if (!rst_hs) begin
      hs_req_p = 1'b0; hs_ack_p = 1'b0; hs_ack_cyc = -1;
    end else begin
      chk("hs_en_low", en_hs, 0);
      chk("hs_done_low", done_hs, 0);
      if (req_hs && !hs_req_p) begin
        chk("hs_q_has_entry", q_hs.size() != 0, 1);
        if (q_hs.size() != 0) begin
          e_hs = q_hs.pop_front();
          chk("hs_data", data_hs, e_hs.d);
          chk("hs_count", cnt_hs, e_hs.c);
          hs_word = e_hs.d;
        end
        hs_ack_cyc = -1;
      end
      if (ack_hs && !hs_ack_p && req_hs) hs_ack_cyc = cyc;
      if (req_hs) chk("hs_data_stable", data_hs, hs_word);
      if (!req_hs && hs_req_p) begin
        chk("hs_data_at_fall", data_hs, hs_word);
        // ack captured on the next edge; req drops two edges after that
        if (hs_ack_cyc >= 0) chk("hs_req_fall_latency", cyc - hs_ack_cyc, 3);
      end
      hs_req_p = req_hs;
      hs_ack_p = ack_hs;
    end
  end

  always @(negedge clk) begin
    if (!rst_st) st_last = -1;
    else begin
      chk("st_req_low", req_st, 0);
      chk("st_done_low", done_st, 0);
      if (en_st) begin
        chk("st_q_has_entry", q_st.size() != 0, 1);
        if (q_st.size() != 0) begin
          e_st = q_st.pop_front();
          chk("st_data", data_st, e_st.d);
          chk("st_count", cnt_st, e_st.c);
        end
        if (st_last >= 0) chk("st_period", cyc - st_last, 5);
        st_last = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_g0) g0_last = -1;
    else begin
      chk("g0_req_low", req_g0, 0);
      if (en_g0) begin
        chk("g0_q_has_entry", q_g0.size() != 0, 1);
        if (q_g0.size() != 0) begin
          e_g0 = q_g0.pop_front();
          chk("g0_data", data_g0, e_g0.d);
          chk("g0_count", cnt_g0, e_g0.c);
        end
        if (g0_last >= 0) chk("g0_period", cyc - g0_last, 2);
        g0_last = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_bu) bu_last = -1;
    else begin
      chk("bu_req_low", req_bu, 0);
      if (done_bu) bu_last = -1;
      if (en_bu) begin
        chk("bu_q_has_entry", q_bu.size() != 0, 1);
        if (q_bu.size() != 0) begin
          e_bu = q_bu.pop_front();
          chk("bu_data", data_bu, e_bu.d);
          chk("bu_count", cnt_bu, e_bu.c);
        end
        if (bu_last >= 0) chk("bu_period", cyc - bu_last, 3);
        bu_last = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      begin : hs_thread
        repeat (2) @(negedge clk);
        chk("hs_rst_data", data_hs, 1);
        chk("hs_rst_req", req_hs, 0);
        chk("hs_rst_count", cnt_hs, 0);
        for (int i = 0; i < 17; i++) q_hs.push_back(word_at(i));
        rst_hs = 1'b1;
        repeat ($urandom_range(3, 1)) @(negedge clk);
        start_hs = 1'b1;
        for (int n = 0; n < 20 && !req_hs; n++) @(negedge clk);
        chk("hs_req_rise_timeout", req_hs, 1);
        for (int n = 0; n < 50; n++) begin
          @(negedge clk);
          chk("hs_stall_req", req_hs, 1);
          start_hs = 1'($urandom_range(1, 0));
        end
        chk("hs_stall_data", data_hs, 1);
        chk("hs_stall_count", cnt_hs, 0);
        rx_block = 1'b0;
        for (int n = 0; n < 1500 && cnt_hs != 8'd17; n++) begin
          @(negedge clk);
          start_hs = 1'($urandom_range(1, 0));
        end
        chk("hs_17_words_timeout", cnt_hs, 17);
        chk("hs_data_after_wrap", data_hs, 2);
        rst_hs = 1'b0;
        q_hs.delete();
        start_hs = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) q_hs.push_back(word_at(i));
        rst_hs = 1'b1;
        @(negedge clk);
        start_hs = 1'b1;
        for (int n = 0; n < 300 && !(req_hs && cnt_hs == 8'd2); n++) @(negedge clk);
        chk("hs_word3_req_timeout", req_hs, 1);
        for (int n = 0; n < 50 && req_hs; n++) @(negedge clk);
        chk("hs_word3_release_timeout", req_hs, 0);
        #2 rst_hs = 1'b0;
        #1;
        chk("hs_midrel_req", req_hs, 0);
        chk("hs_midrel_count", cnt_hs, 0);
        chk("hs_midrel_data", data_hs, 1);
        q_hs.delete();
        start_hs = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 2; i++) q_hs.push_back(word_at(i));
        rst_hs = 1'b1;
        @(negedge clk);
        start_hs = 1'b1;
        for (int n = 0; n < 200 && !(req_hs && cnt_hs == 8'd1); n++) @(negedge clk);
        chk("hs_restart_word2_timeout", req_hs && cnt_hs == 8'd1, 1);
        #2 rst_hs = 1'b0;
        #1;
        chk("hs_midreq_req", req_hs, 0);
        chk("hs_midreq_data", data_hs, 1);
        chk("hs_q_drained", q_hs.size(), 0);
      end
      begin : st_thread
        repeat (2) @(negedge clk);
        chk("st_rst_data", data_st, 1);
        chk("st_rst_en", en_st, 0);
        chk("st_rst_count", cnt_st, 0);
        for (int i = 0; i < 20; i++) q_st.push_back(word_at(i));
        rst_st = 1'b1;
        repeat ($urandom_range(3, 0)) @(negedge clk);
        start_st = 1'b1;
        repeat (3) @(negedge clk);
        for (int n = 0; n < 300 && cnt_st != 8'd20; n++) begin
          @(negedge clk);
          start_st = 1'($urandom_range(1, 0));
        end
        chk("st_20_words_timeout", cnt_st, 20);
        rst_st = 1'b0;
        chk("st_q_drained", q_st.size(), 0);
      end
      begin : g0_thread
        repeat (2) @(negedge clk);
        chk("g0_rst_data", data_g0, 1);
        chk("g0_rst_count", cnt_g0, 0);
        for (int i = 0; i < 40; i++) q_g0.push_back(word_at(i));
        rst_g0 = 1'b1;
        repeat ($urandom_range(3, 0)) @(negedge clk);
        start_g0 = 1'b1;
        for (int n = 0; n < 200 && cnt_g0 != 8'd40; n++) @(negedge clk);
        chk("g0_40_words_timeout", cnt_g0, 40);
        rst_g0 = 1'b0;
        chk("g0_q_drained", q_g0.size(), 0);
      end
      begin : bu_thread
        repeat (2) @(negedge clk);
        chk("bu_rst_done", done_bu, 0);
        chk("bu_rst_data", data_bu, 1);
        for (int i = 0; i < 4; i++) q_bu.push_back(word_at(i));
        rst_bu = 1'b1;
        repeat ($urandom_range(3, 0)) @(negedge clk);
        start_bu = 1'b1;
        for (int n = 0; n < 100 && !done_bu; n++) @(negedge clk);
        chk("bu_done1_timeout", done_bu, 1);
        repeat (5) @(negedge clk);
        chk("bu_done1_held", done_bu, 1);
        chk("bu_done1_count", cnt_bu, 4);
        chk("bu_done1_data", data_bu, 5);
        start_bu = 1'b0;
        @(negedge clk);
        chk("bu_done_drop", done_bu, 0);
        repeat (3) @(negedge clk);
        chk("bu_idle_count_kept", cnt_bu, 4);
        chk("bu_idle_data_kept", data_bu, 5);
        for (int i = 4; i < 8; i++) q_bu.push_back(word_at(i));
        start_bu = 1'b1;
        for (int n = 0; n < 100 && !done_bu; n++) @(negedge clk);
        chk("bu_done2_timeout", done_bu, 1);
        chk("bu_done2_count", cnt_bu, 8);
        chk("bu_done2_data", data_bu, 9);
        rst_bu = 1'b0;
        chk("bu_q_drained", q_bu.size(), 0);
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
